// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC / instruction-fetch sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: trap vector beats redirect target beats pc+4.
// Redirect/trap targets are forced word aligned; pc+4 wraps modulo 2^32.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic [31:0] pc,
  input  logic        trap_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        jump,
  output logic [31:0] next_pc
);

  // Select the next fetch address in priority order.
  always_comb begin
    jump    = trap_valid | redirect_valid;
    next_pc = pc + INSTR_BYTES;
    if (trap_valid)
      next_pc = TRAP_VECTOR & ALIGN_MASK;
    else if (redirect_valid)
      next_pc = redirect_pc & ALIGN_MASK;
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC register, single-outstanding fetch FSM and one-entry instruction buffer.
// A redirect/trap that lands after a request has been accepted marks the
// in-flight response for discard (drop) instead of cancelling it on the bus.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap_valid
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic         drop, drop_nxt;
  logic [31:0]  instr_q, instr_nxt;
  logic [31:0]  ifpc_q, ifpc_nxt;
  logic         jump;
  logic [31:0]  sel_pc;

  pc_next_sel #(.TRAP_VECTOR(TRAP_VECTOR)) u_next_sel (
    .pc             (pc),
    .trap_valid     (trap_valid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .jump           (jump),
    .next_pc        (sel_pc)
  );

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign if_valid       = (state == HOLD);
  assign if_pc          = ifpc_q;
  assign if_instr       = instr_q;

  // Next-state, PC, drop flag and buffer update.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop;
    instr_nxt = instr_q;
    ifpc_nxt  = ifpc_q;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (jump) pc_nxt = sel_pc;
        if (imem_req_ready) begin
          state_nxt = WAIT;
          drop_nxt  = jump;
        end
      end
      WAIT: begin
        if (jump) begin
          pc_nxt = sel_pc;
          if (imem_rsp_valid) begin
            state_nxt = REQ;
            drop_nxt  = 1'b0;
          end else begin
            drop_nxt  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop) begin
            drop_nxt  = 1'b0;
            state_nxt = REQ;
          end else begin
            instr_nxt = imem_rsp_data;
            ifpc_nxt  = pc;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (jump || if_ready) begin
          pc_nxt    = sel_pc;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      pc      <= RESET_VECTOR;
      drop    <= 1'b0;
      instr_q <= 32'h0;
      ifpc_q  <= RESET_VECTOR;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      drop    <= drop_nxt;
      instr_q <= instr_nxt;
      ifpc_q  <= ifpc_nxt;
    end
  end

endmodule
